// File: rtl/led_blink_code_if.sv
// led_blink_code_if: start/code request and LED/busy/done status of the blink-code driver.
interface led_blink_code_if #(
    parameter int CODE_W = 4
);
    logic              start;
    logic [CODE_W-1:0] code;
    logic              repeat_en;
    logic              abort;
    logic              led;
    logic              busy;
    logic              done;

    modport master (output start, code, repeat_en, abort, input led, busy, done);
    modport slave  (input start, code, repeat_en, abort, output led, busy, done);
endinterface

// File: rtl/led_blink_code.sv
// led_blink_code: plays a numeric code as N LED blinks followed by a dark gap, optionally repeating.
module led_blink_code #(
    parameter int ON_CYCLES      = 25_000_000,
    parameter int OFF_CYCLES     = 25_000_000,
    parameter int GAP_CYCLES     = 100_000_000,
    parameter int CODE_W         = 4,
    parameter int LED_ACTIVE_LOW = 0
) (
    input logic             clk,
    input logic             reset,
    led_blink_code_if.slave bus
);
    localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ?
                           ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) :
                           ((OFF_CYCLES > GAP_CYCLES) ? OFF_CYCLES : GAP_CYCLES);
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic POL = (LED_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [CODE_W-1:0] r_blinks, w_blinks;
    logic [CODE_W-1:0] r_code, w_code;
    logic              r_led, r_busy, r_done, w_done;

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt + 1'b1;
        w_blinks = r_blinks;
        w_code   = r_code;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (bus.start && !bus.abort) begin
                    if (bus.code != '0) begin
                        w_state  = ON;
                        w_code   = bus.code;
                        w_blinks = bus.code;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ON: if (r_cnt == ON_LAST) begin
                w_cnt    = '0;
                w_blinks = r_blinks - 1'b1;
                w_state  = (r_blinks == CODE_W'(1)) ? GAP : OFF;
            end
            OFF: if (r_cnt == OFF_LAST) begin
                w_cnt   = '0;
                w_state = ON;
            end
            GAP: if (r_cnt == GAP_LAST) begin
                w_cnt = '0;
                if (bus.repeat_en) begin
                    w_state  = ON;
                    w_blinks = r_code;
                end else begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
        // abort overrides every counter transition, including the repeat decision
        if (bus.abort && r_state != IDLE) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_blinks <= '0;
            r_code   <= '0;
            r_led    <= POL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_blinks <= w_blinks;
            r_code   <= w_code;
            r_led    <= (w_state == ON) ^ POL;
            r_busy   <= (w_state != IDLE);
            r_done   <= w_done;
        end
    end

    assign bus.led  = r_led;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
